// File: rtl/squid_encode_ctrl_if.sv
// Weight-in / encoded-block-out bundle for squid_encode_ctrl.
// slave = controller side, master = upstream/encoder/downstream side.
interface squid_encode_ctrl_if;
  logic        w_valid;
  logic [5:0]  w_data;
  logic        w_last;
  logic        w_ready;
  logic [47:0] enc_block;
  logic [15:0] enc_pp;
  logic        out_valid;
  logic [15:0] out_pp;
  logic        out_pad;
  logic        out_ready;

  modport slave (
    input  w_valid,
    input  w_data,
    input  w_last,
    output w_ready,
    output enc_block,
    input  enc_pp,
    output out_valid,
    output out_pp,
    output out_pad,
    input  out_ready
  );

  modport master (
    output w_valid,
    output w_data,
    output w_last,
    input  w_ready,
    input  enc_block,
    output enc_pp,
    input  out_valid,
    input  out_pp,
    input  out_pad,
    output out_ready
  );
endinterface

// File: rtl/squid_encode_ctrl.sv
// Collects 6-bit weights into 8-slot blocks, hands them to the
// encoder datapath, and holds the registered result until taken.
module squid_encode_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  squid_encode_ctrl_if.slave bus,
  output logic [CNT_W-1:0] blk_cnt
);

  typedef enum logic [1:0] {
    FILL,
    ENC,
    OUT
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [5:0]       slot_q [8];
  logic [5:0]       slot_d [8];
  logic             pad_q, pad_d;
  logic [15:0]      pp_q, pp_d;
  logic             opad_q, opad_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [47:0]      blk;
  logic             acc;
  logic             dlv;
  logic             close;

  assign bus.w_ready   = (state_q == FILL) & ~rst;
  assign bus.out_valid = (state_q == OUT) & ~rst;
  assign bus.out_pp    = pp_q;
  assign bus.out_pad   = opad_q;
  assign bus.enc_block = blk;
  assign blk_cnt       = cnt_q;

  assign acc   = bus.w_valid & bus.w_ready;
  assign dlv   = bus.out_valid & bus.out_ready;
  assign close = bus.w_last | (idx_q == 3'd7);

  // Pack slot registers onto the encoder bus, slot 0 in the low bits.
  always_comb begin
    blk = '0;
    for (int k = 0; k < 8; k++) begin
      blk[6*k +: 6] = slot_q[k];
    end
  end

  // Next-state and datapath updates for the fill/encode/output cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pad_d   = pad_q;
    pp_d    = pp_q;
    opad_d  = opad_q;
    cnt_d   = cnt_q;
    for (int k = 0; k < 8; k++) begin
      slot_d[k] = slot_q[k];
    end
    unique case (state_q)
      FILL: begin
        if (acc) begin
          slot_d[idx_q] = bus.w_data;
          if (close) begin
            idx_d   = 3'd0;
            state_d = ENC;
            if (idx_q != 3'd7) begin
              pad_d = 1'b1;
              for (int k = 0; k < 8; k++) begin
                if (3'(k) > idx_q) begin
                  slot_d[k] = '0;
                end
              end
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      ENC: begin
        pp_d    = bus.enc_pp;
        opad_d  = pad_q;
        state_d = OUT;
      end
      OUT: begin
        if (dlv) begin
          for (int k = 0; k < 8; k++) begin
            slot_d[k] = '0;
          end
          pad_d   = 1'b0;
          cnt_d   = cnt_q + 1'b1;
          state_d = FILL;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // State registers; reset drops any partial or pending block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      idx_q   <= '0;
      pad_q   <= 1'b0;
      pp_q    <= '0;
      opad_q  <= 1'b0;
      cnt_q   <= '0;
      for (int k = 0; k < 8; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pad_q   <= pad_d;
      pp_q    <= pp_d;
      opad_q  <= opad_d;
      cnt_q   <= cnt_d;
      for (int k = 0; k < 8; k++) begin
        slot_q[k] <= slot_d[k];
      end
    end
  end

endmodule

// File: tb/tb_squid_encode_ctrl.sv
// Directed plus randomized block traffic against a transaction-level
// model of squid_encode_ctrl, with an arbitrary combinational encoder.
module tb_squid_encode_ctrl;

  localparam int CNT_W = 2;

  logic             clk;
  logic             rst;
  logic [CNT_W-1:0] blk_cnt;

  squid_encode_ctrl_if ifc();

  squid_encode_ctrl #(.CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (ifc),
    .blk_cnt (blk_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] enc_fn(input logic [47:0] b);
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = b[12*k +: 4] ^ b[12*k+6 +: 4]
                  ^ {b[12*k+4 +: 2], b[12*k+10 +: 2]}
                  ^ 4'(k);
    end
    return r;
  endfunction

  assign ifc.enc_pp = enc_fn(ifc.enc_block);

  int unsigned      n_tests;
  int unsigned      n_fail;
  int unsigned      exp_cnt;
  logic [5:0]       wq [8];

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    ifc.w_valid   = 1'b0;
    ifc.out_ready = 1'b0;
    @(negedge clk);
    check("rst_wready", 64'(ifc.w_ready), 64'd0);
    check("rst_oval", 64'(ifc.out_valid), 64'd0);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    check("post_rst_wready", 64'(ifc.w_ready), 64'd1);
    check("post_rst_oval", 64'(ifc.out_valid), 64'd0);
    check("post_rst_cnt", 64'(blk_cnt), 64'd0);
    check("post_rst_pp", 64'(ifc.out_pp), 64'd0);
    check("post_rst_pad", 64'(ifc.out_pad), 64'd0);
    check("post_rst_blk", 64'(ifc.enc_block), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Feed wq[0..n-1], then check ENC, OUT (with stall) and delivery.
  task automatic run_block(input int n, input bit use_last,
                           input bit gapped, input int stall);
    logic [47:0] eb;
    logic [15:0] epp;
    logic        epad;
    eb = '0;
    for (int i = 0; i < n; i++) eb[6*i +: 6] = wq[i];
    epp  = enc_fn(eb);
    epad = (n < 8);
    ifc.out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gapped) begin
        ifc.w_valid = 1'b0;
        ifc.w_data  = 6'($urandom);
        ifc.w_last  = 1'($urandom);
        @(negedge clk);
        check("gap_wready", 64'(ifc.w_ready), 64'd1);
        @(posedge clk);
        #1;
      end
      ifc.w_valid = 1'b1;
      ifc.w_data  = wq[i];
      ifc.w_last  = use_last && (i == n - 1);
      @(negedge clk);
      check("fill_wready", 64'(ifc.w_ready), 64'd1);
      check("fill_oval", 64'(ifc.out_valid), 64'd0);
      @(posedge clk);
      #1;
    end
    ifc.w_valid = 1'b1;
    ifc.w_data  = 6'($urandom);
    ifc.w_last  = 1'($urandom);
    @(negedge clk);
    check("enc_wready", 64'(ifc.w_ready), 64'd0);
    check("enc_oval", 64'(ifc.out_valid), 64'd0);
    check("enc_blk", 64'(ifc.enc_block), 64'(eb));
    @(posedge clk);
    #1;
    for (int s = 0; s <= stall; s++) begin
      ifc.out_ready = (s == stall);
      ifc.w_data    = 6'($urandom);
      ifc.w_last    = 1'($urandom);
      @(negedge clk);
      check("out_oval", 64'(ifc.out_valid), 64'd1);
      check("out_pp", 64'(ifc.out_pp), 64'(epp));
      check("out_pad", 64'(ifc.out_pad), 64'(epad));
      check("out_blk", 64'(ifc.enc_block), 64'(eb));
      check("out_wready", 64'(ifc.w_ready), 64'd0);
      check("out_cnt", 64'(blk_cnt), 64'(exp_cnt));
      @(posedge clk);
      #1;
    end
    exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    ifc.w_valid   = 1'b0;
    ifc.out_ready = 1'b0;
    @(negedge clk);
    check("dlv_oval", 64'(ifc.out_valid), 64'd0);
    check("dlv_wready", 64'(ifc.w_ready), 64'd1);
    check("dlv_cnt", 64'(blk_cnt), 64'(exp_cnt));
    check("dlv_blk_clr", 64'(ifc.enc_block), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    exp_cnt       = 0;
    rst           = 1'b1;
    ifc.w_valid   = 1'b0;
    ifc.w_data    = '0;
    ifc.w_last    = 1'b0;
    ifc.out_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Full block 1..8, immediate delivery.
    for (int i = 0; i < 8; i++) wq[i] = 6'(i + 1);
    run_block(8, 1'b0, 1'b0, 0);

    // Same block with five cycles of backpressure.
    run_block(8, 1'b0, 1'b0, 5);

    // Partial block 5, 9, 63 closed by w_last.
    wq[0] = 6'd5;
    wq[1] = 6'd9;
    wq[2] = 6'd63;
    run_block(3, 1'b1, 1'b0, 0);

    // Gapped random words.
    for (int i = 0; i < 8; i++) wq[i] = 6'($urandom);
    run_block(8, 1'b0, 1'b1, 1);

    // w_last on the eighth word is a full, unpadded block.
    for (int i = 0; i < 8; i++) wq[i] = 6'($urandom);
    run_block(8, 1'b1, 1'b0, 0);

    // Single-word block.
    wq[0] = 6'($urandom_range(1, 63));
    run_block(1, 1'b1, 1'b0, 2);

    // Reset while a block is pending in OUT.
    for (int i = 0; i < 8; i++) begin
      ifc.w_valid = 1'b1;
      ifc.w_data  = 6'($urandom);
      ifc.w_last  = 1'b0;
      @(posedge clk);
      #1;
    end
    ifc.w_valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("pre_rst_oval", 64'(ifc.out_valid), 64'd1);
    @(posedge clk);
    #1;
    do_reset();
    for (int i = 0; i < 8; i++) wq[i] = 6'($urandom);
    run_block(8, 1'b0, 1'b0, 0);

    // Reset mid-fill discards the partial words.
    for (int i = 0; i < 3; i++) begin
      ifc.w_valid = 1'b1;
      ifc.w_data  = 6'h3f;
      ifc.w_last  = 1'b0;
      @(posedge clk);
      #1;
    end
    do_reset();

    // Counter wrap over five random blocks: 1, 2, 3, 0, 1.
    for (int b = 0; b < 5; b++) begin
      int n;
      n = $urandom_range(1, 8);
      for (int i = 0; i < 8; i++) wq[i] = 6'($urandom);
      run_block(n, 1'b1, 1'($urandom), $urandom_range(0, 3));
    end
    check("wrap_final", 64'(blk_cnt), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/squid_encode_ctrl.md
SQUID_ENCODE_CTRL -- requirements
Module: squid_encode_ctrl

Interface
REQ-001 Parameter CNT_W, default 16: width of the encoded-block counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 w_valid  input  1  upstream weight word valid.
REQ-005 w_data  input  6  one 6-bit weight.
REQ-006 w_last  input  1  marks final word of a stream; closes a partial block.
REQ-007 w_ready  output  1  controller accepts a weight this cycle.
REQ-008 enc_block  output  48  8 x 6-bit slots to the encoder datapath; slot k = bits [6k+5:6k].
REQ-009 enc_pp  input  16  4 x 4-bit encoder result, combinational from enc_block.
REQ-010 out_valid  output  1  encoded block available.
REQ-011 out_pp  output  16  registered encoder result.
REQ-012 out_pad  output  1  block was zero-padded (closed by w_last before 8 words).
REQ-013 out_ready  input  1  downstream accepts the encoded block.
REQ-014 blk_cnt  output  CNT_W  number of blocks delivered since reset.

Function
REQ-015 FSM states: FILL, ENC, OUT; exactly one active.
REQ-016 Handshake rule: w_ready = 1 only in FILL; a word is accepted on a rising edge where w_valid & w_ready.
REQ-017 Handshake rule: out_valid = 1 only in OUT; a block is delivered on a rising edge where out_valid & out_ready.
REQ-018 FILL: each accepted word is written to slot idx; idx (3-bit) then increments.
REQ-019 FILL -> ENC on an accept with idx == 7 or with w_last = 1; idx returns to 0.
REQ-020 Padding: on a w_last accept with idx < 7, slots idx+1..7 hold 0, and pad_flag is set.
REQ-021 enc_block is driven from the slot registers and is held stable in ENC and OUT.
REQ-022 ENC lasts exactly one cycle. At its end, out_pp <= enc_pp and out_pad <= pad_flag; state moves to OUT.
REQ-023 Latency: a closing accept at edge N gives out_valid = 1 from the cycle after edge N+1.
REQ-024 Throughput: at most one block per 10 cycles (8 FILL + ENC + OUT) with out_ready held at 1.
REQ-025 OUT: out_valid, out_pp and out_pad are held unchanged while out_ready = 0, with no timeout.
REQ-026 OUT -> FILL on delivery: all slots cleared to 0, pad_flag cleared, blk_cnt incremented.
REQ-027 blk_cnt wraps modulo 2^CNT_W; all-ones + 1 gives 0.
REQ-028 w_valid in ENC/OUT is ignored: no accept, and w_data and w_last are not sampled.
REQ-029 w_last with w_valid = 0 has no effect.
REQ-030 A w_last accept with idx == 7 is a full block: out_pad = 0.
REQ-031 No combinational path from out_ready to w_ready; w_ready depends on state only.

Reset
REQ-032 rst = 1 at a rising edge forces: state FILL, idx 0, all slots 0, pad_flag 0, out_pp 0, out_pad 0, blk_cnt 0.
REQ-033 During the reset cycle: w_ready 0 and out_valid 0; from the first cycle after rst deasserts: w_ready 1.
REQ-034 rst mid-block (FILL with idx > 0, ENC, or OUT) discards partial or pending data; no block is delivered and blk_cnt is not incremented.

Verification
REQ-035 Full block, out_ready = 1: words 1..8 on consecutive cycles -> w_ready low 2 cycles; out_valid one cycle; out_pp = enc_pp for slots {1..8}; out_pad 0; blk_cnt 1.
REQ-036 Backpressure: as REQ-035 but out_ready 0 for 5 cycles -> out_valid and out_pp stable for 5 cycles; w_ready 0 throughout; delivered on the 6th cycle.
REQ-037 Partial block: words 5, 9, 63 with w_last on 63 -> enc_block = {63, 9, 5} in slots 2..0, slots 3..7 = 0; out_pad 1.
REQ-038 Gapped input: w_valid toggling 1/0 over 16 cycles -> 8 accepts; slot order preserved; exactly one block.
REQ-039 Reset in OUT: rst pulse while out_valid = 1 -> next cycle out_valid 0, blk_cnt 0, w_ready 1; a new full block is encoded correctly.
REQ-040 Counter wrap: CNT_W = 2, 5 blocks delivered -> blk_cnt reads 1, 2, 3, 0, 1.
